// File: rtl/timebase_pkg.sv
// Shared types and default sizes for the sweep timebase generator.
// TIMEBASE_HOLDOFF_EN adds the HOLDOFF state between continuous sweeps.
package timebase_pkg;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned HO_W_DEF  = 8;

`ifdef TIMEBASE_HOLDOFF_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLDOFF = 2'd2
  } tb_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } tb_state_t;
`endif

endpackage

// File: rtl/tb_prescaler.sv
// Power-of-two prescaler: tick is high on the last count of each 2^div_sel period.
module tb_prescaler #(
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [SEL_W-1:0] div_sel,
  output logic             tick
);

  localparam int unsigned CW = (1 << SEL_W) - 1;

  logic [CW-1:0] cnt;
  logic [CW:0]   lim_c;

  assign lim_c = (CW+1)'(1) << div_sel;
  assign tick  = ({1'b0, cnt} == (lim_c - (CW+1)'(1)));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/timebase_gen.sv
// Sweep timebase: emits DEPTH sample strobes spaced 2^active_div cycles apart.
// TIMEBASE_HOLDOFF_EN inserts a programmable idle gap between continuous sweeps.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned HO_W  = HO_W_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         time_div,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
`ifdef TIMEBASE_HOLDOFF_EN
  input  logic [HO_W-1:0]          holdoff,
`endif
  output logic                     sample_en,
  output logic [$clog2(DEPTH)-1:0] sample_idx,
  output logic                     sweep_done,
  output logic                     busy,
  output logic [SEL_W-1:0]         active_div
);

  localparam int unsigned IW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HO_W < 1) begin : g_bad_param
    $error("timebase_gen: DEPTH must be a power of two >= 2 and HO_W >= 1");
  end

  tb_state_t        state, state_d;
  logic             sample_en_d, sweep_done_d;
  logic [IW-1:0]    sample_idx_d;
  logic [IW-1:0]    idx_cnt, idx_cnt_d;
  logic [SEL_W-1:0] active_div_d;
  logic             end_pend, end_pend_d;
  logic             tick;
  logic             clr_c;
`ifdef TIMEBASE_HOLDOFF_EN
  logic [HO_W-1:0]  ho_cnt, ho_cnt_d;
`endif

  // Prescaler idles at zero outside live counting so every sweep starts aligned.
  assign clr_c = (state != RUN) || end_pend;

  tb_prescaler #(.SEL_W(SEL_W)) u_prescaler (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .div_sel (active_div),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state;
    sample_en_d  = 1'b0;
    sweep_done_d = 1'b0;
    sample_idx_d = sample_idx;
    idx_cnt_d    = idx_cnt;
    active_div_d = active_div;
    end_pend_d   = 1'b0;
`ifdef TIMEBASE_HOLDOFF_EN
    ho_cnt_d     = ho_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          active_div_d = time_div;
          idx_cnt_d    = '0;
          sample_idx_d = '0;
        end
      end
      RUN: begin
        if (end_pend) begin
`ifdef TIMEBASE_HOLDOFF_EN
          if (continuous) begin
            state_d  = HOLDOFF;
            ho_cnt_d = holdoff;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (tick) begin
          sample_en_d  = 1'b1;
          sample_idx_d = idx_cnt;
          idx_cnt_d    = idx_cnt + IW'(1);
          if (idx_cnt == IW'(DEPTH - 1)) begin
            sweep_done_d = 1'b1;
`ifdef TIMEBASE_HOLDOFF_EN
            end_pend_d   = 1'b1;
`else
            // Restart on the last strobe edge keeps spacing at exactly R_new.
            if (continuous) begin
              active_div_d = time_div;
              idx_cnt_d    = '0;
            end else begin
              end_pend_d = 1'b1;
            end
`endif
          end
        end
      end
`ifdef TIMEBASE_HOLDOFF_EN
      HOLDOFF: begin
        if (ho_cnt <= HO_W'(1)) begin
          state_d      = RUN;
          active_div_d = time_div;
          idx_cnt_d    = '0;
          sample_idx_d = '0;
        end else begin
          ho_cnt_d = ho_cnt - HO_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start in IDLE.
    if (stop) begin
      state_d      = IDLE;
      sample_en_d  = 1'b0;
      sweep_done_d = 1'b0;
      end_pend_d   = 1'b0;
      sample_idx_d = sample_idx;
      idx_cnt_d    = idx_cnt;
      active_div_d = active_div;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_en  <= 1'b0;
      sweep_done <= 1'b0;
      sample_idx <= '0;
      idx_cnt    <= '0;
      active_div <= '0;
      end_pend   <= 1'b0;
      busy       <= 1'b0;
`ifdef TIMEBASE_HOLDOFF_EN
      ho_cnt     <= '0;
`endif
    end else begin
      state      <= state_d;
      sample_en  <= sample_en_d;
      sweep_done <= sweep_done_d;
      sample_idx <= sample_idx_d;
      idx_cnt    <= idx_cnt_d;
      active_div <= active_div_d;
      end_pend   <= end_pend_d;
      busy       <= (state_d != IDLE);
`ifdef TIMEBASE_HOLDOFF_EN
      ho_cnt     <= ho_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen: strobe scoreboard plus directed corner sequences.
module tb_timebase_gen;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HO_W  = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic [SEL_W-1:0] time_div;
  logic             start, stop, continuous;
`ifdef TIMEBASE_HOLDOFF_EN
  logic [HO_W-1:0]  holdoff;
`endif
  logic             sample_en, sweep_done, busy;
  logic [1:0]       sample_idx;
  logic [SEL_W-1:0] active_div;

  timebase_gen #(.SEL_W(SEL_W), .DEPTH(DEPTH), .HO_W(HO_W)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .time_div   (time_div),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
`ifdef TIMEBASE_HOLDOFF_EN
    .holdoff    (holdoff),
`endif
    .sample_en  (sample_en),
    .sample_idx (sample_idx),
    .sweep_done (sweep_done),
    .busy       (busy),
    .active_div (active_div)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    int done;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [SEL_W-1:0] div;
    logic [SEL_W-1:0] mid_div;
    int               period;
  } vec_t;
  vec_t tbl[5];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_sweep(input int k, input int per);
    for (int i = 0; i < int'(DEPTH); i++) begin
      q.push_back('{cyc: k + per * (i + 1), idx: i, done: (i == int'(DEPTH) - 1) ? 1 : 0});
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Every observed strobe must match the next expected one in cycle, index and done flag.
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && sample_en === 1'b1) begin
      check("strobe_expected", (q.size() > 0) ? 1 : 0, 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_idx", int'(sample_idx), e.idx);
        check("strobe_done", int'(sweep_done), e.done);
      end
    end
  end

  task automatic run_single(input vec_t v);
    int k;
    @(negedge clk_in);
    time_div = v.div;
    start    = 1'b1;
    k        = cyc + 1;
    push_sweep(k, v.period);
    @(negedge clk_in);
    start = 1'b0;
    check("active_div_latched", int'(active_div), int'(v.div));
    check("busy_running", int'(busy), 1);
    time_div = v.mid_div;
    tick_to(k + int'(DEPTH) * v.period);
    check("busy_last_strobe", int'(busy), 1);
    tick_to(k + int'(DEPTH) * v.period + 1);
    check("busy_after_sweep", int'(busy), 0);
    check("idx_hold_after_sweep", int'(sample_idx), int'(DEPTH) - 1);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int k;
    tbl[0] = '{div: 3'd0, mid_div: 3'd0, period: 1};
    tbl[1] = '{div: 3'd3, mid_div: 3'd1, period: 8};
    tbl[2] = '{div: 3'd1, mid_div: 3'd7, period: 2};
    tbl[3] = '{div: 3'd2, mid_div: 3'd0, period: 4};
    tbl[4] = '{div: 3'd5, mid_div: 3'd2, period: 32};

    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    time_div   = 3'd4;
`ifdef TIMEBASE_HOLDOFF_EN
    holdoff    = '0;
`endif
    repeat (3) @(negedge clk_in);
    check("rst_sample_en", int'(sample_en), 0);
    check("rst_sweep_done", int'(sweep_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sample_idx", int'(sample_idx), 0);
    check("rst_active_div", int'(active_div), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_single(tbl[i]);

`ifndef TIMEBASE_HOLDOFF_EN
    // Continuous restart picks up the new rate exactly one new period after the last strobe.
    @(negedge clk_in);
    continuous = 1'b1;
    time_div   = 3'd2;
    start      = 1'b1;
    k          = cyc + 1;
    push_sweep(k, 4);
    push_sweep(k + 16, 2);
    @(negedge clk_in);
    start = 1'b0;
    tick_to(k + 10);
    time_div = 3'd1;
    tick_to(k + 17);
    check("cont_active_div_new", int'(active_div), 1);
    continuous = 1'b0;
    tick_to(k + 24);
    check("cont_busy_last", int'(busy), 1);
    tick_to(k + 25);
    check("cont_busy_end", int'(busy), 0);
    check("cont_queue_drained", q.size(), 0);
`else
    // Holdoff gap: five idle busy cycles, then a fresh sweep.
    @(negedge clk_in);
    continuous = 1'b1;
    holdoff    = 8'd5;
    time_div   = 3'd0;
    start      = 1'b1;
    k          = cyc + 1;
    push_sweep(k, 1);
    push_sweep(k + 10, 1);
    @(negedge clk_in);
    start = 1'b0;
    tick_to(k + 5);
    for (int c = 0; c < 5; c++) begin
      check("holdoff_busy", int'(busy), 1);
      check("holdoff_no_strobe", int'(sample_en), 0);
      if (c == 0) continuous = 1'b0;
      @(negedge clk_in);
    end
    tick_to(k + 15);
    check("holdoff_busy_end", int'(busy), 0);
    check("holdoff_queue_drained", q.size(), 0);
`endif

    // Abort at index 2, with a start while busy that must be ignored.
    @(negedge clk_in);
    time_div = 3'd1;
    start    = 1'b1;
    k        = cyc + 1;
    for (int i = 0; i < 3; i++) q.push_back('{cyc: k + 2 * (i + 1), idx: i, done: 0});
    @(negedge clk_in);
    start = 1'b0;
    tick_to(k + 3);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    tick_to(k + 6);
    check("stop_idx_before", int'(sample_idx), 2);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_sample_en", int'(sample_en), 0);
    check("stop_sweep_done", int'(sweep_done), 0);
    tick_to(k + 20);
    check("stop_idx_hold", int'(sample_idx), 2);
    check("stop_queue_drained", q.size(), 0);

    // Start and stop together in IDLE stays idle.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", int'(busy), 0);
    repeat (10) @(negedge clk_in);
    check("startstop_busy_later", int'(busy), 0);

    // Asynchronous reset in the middle of a strobe cycle.
    @(negedge clk_in);
    time_div = 3'd1;
    start    = 1'b1;
    k        = cyc + 1;
    q.push_back('{cyc: k + 2, idx: 0, done: 0});
    q.push_back('{cyc: k + 4, idx: 1, done: 0});
    @(negedge clk_in);
    start = 1'b0;
    tick_to(k + 4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_sample_en", int'(sample_en), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_sample_idx", int'(sample_idx), 0);
    check("arst_active_div", int'(active_div), 0);
    check("arst_sweep_done", int'(sweep_done), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_in);
    check("arst_busy_after", int'(busy), 0);
    check("final_queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
